if_fetch_stage: RTL and testbench

Instruction-fetch stage directly upstream of the IF/ID pipeline register. It owns the architectural PC, looks the PC up in a small direct-mapped instruction cache, and on a miss issues a word fetch to the memory controller. It delivers one instruction per cycle on hit (instE/pc/inst) and redirects on jump/branch from EX.

---
 rtl/if_fetch_stage_pkg.sv | 24 ++
 rtl/if_icache.sv | 54 +++++
 rtl/if_fetch_stage.sv | 131 +++++++++++++
 tb/tb_if_fetch_stage.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_stage_pkg.sv
// Shared widths, control encodings and FSM state type for the instruction-fetch stage.
package if_fetch_stage_pkg;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned INST_W  = 32;
  localparam int unsigned STALL_W = 6;

  localparam logic STALL    = 1'b1;
  localparam logic NO_STALL = 1'b0;
  localparam logic JUMP     = 1'b1;
  localparam logic ENABLE   = 1'b1;

  localparam logic [ADDR_W-1:0] ZERO32 = '0;

  typedef enum logic [0:0] {
    StIdle,
    StWaitMem
  } fetch_state_e;

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/if_icache.sv
// Direct-mapped, one-word-per-line instruction cache: combinational lookup, synchronous fill,
// valid bits cleared only by reset.
module if_icache
  import if_fetch_stage_pkg::*;
#(
  parameter int unsigned ICACHE_IDX_W = 5
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [ADDR_W-1:2] i_lookup_addr,
  output logic              o_hit,
  output logic [INST_W-1:0] o_data,
  input  logic              i_we,
  input  logic [ADDR_W-1:2] i_waddr,
  input  logic [INST_W-1:0] i_wdata
);

  localparam int unsigned Lines = 1 << ICACHE_IDX_W;
  localparam int unsigned TagW  = ADDR_W - ICACHE_IDX_W - 2;

  logic [Lines-1:0]  r_valid;
  logic [TagW-1:0]   r_tag  [Lines];
  logic [INST_W-1:0] r_data [Lines];

  logic [ICACHE_IDX_W-1:0] w_lk_idx;
  logic [TagW-1:0]         w_lk_tag;
  logic [ICACHE_IDX_W-1:0] w_wr_idx;
  logic [TagW-1:0]         w_wr_tag;

  assign w_lk_idx = i_lookup_addr[ICACHE_IDX_W+1:2];
  assign w_lk_tag = i_lookup_addr[ADDR_W-1:ICACHE_IDX_W+2];
  assign w_wr_idx = i_waddr[ICACHE_IDX_W+1:2];
  assign w_wr_tag = i_waddr[ADDR_W-1:ICACHE_IDX_W+2];

  assign o_hit  = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
  assign o_data = r_data[w_lk_idx];

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_valid <= '0;
    end else if (i_we) begin
      r_valid[w_wr_idx] <= 1'b1;
    end
  end

  // Tag/data need no reset: they are never observed while the line is invalid.
  always_ff @(posedge clk_in) begin
    if (i_we) begin
      r_tag[w_wr_idx]  <= w_wr_tag;
      r_data[w_wr_idx] <= i_wdata;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Fetch stage: owns the PC, delivers one instruction per cycle on cache hit, fetches a word
// from memory on miss, and redirects on jump from EX.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter int unsigned       ICACHE_IDX_W = 5,
  parameter logic [ADDR_W-1:0] RESET_PC     = 32'h0
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic [STALL_W-1:0] stall_in,
  input  logic               pcJump_in,
  input  logic [ADDR_W-1:0]  pcTarget_in,
  input  logic               memDone_in,
  input  logic [INST_W-1:0]  memData_in,
  output logic               memReq_out,
  output logic [ADDR_W-1:0]  memAddr_out,
  output logic               instE_out,
  output logic [ADDR_W-1:0]  pc_out,
  output logic [INST_W-1:0]  inst_out
);

  fetch_state_e      r_state, w_state_d;
  logic [ADDR_W-1:0] r_pc, w_pc_d;
  logic              r_mem_req, w_mem_req_d;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_d;
  logic              r_inst_e, w_inst_e_d;
  logic [ADDR_W-1:0] r_pc_out, w_pc_out_d;
  logic [INST_W-1:0] r_inst_out, w_inst_out_d;

  logic              w_hit;
  logic [INST_W-1:0] w_hit_data;
  logic              w_fill;
  logic              w_stall;
  logic              w_stall_unused;

  assign w_stall        = (stall_in[0] == STALL);
  assign w_stall_unused = ^stall_in[STALL_W-1:1];

  if_icache #(
    .ICACHE_IDX_W(ICACHE_IDX_W)
  ) u_icache (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .i_lookup_addr(r_pc[ADDR_W-1:2]),
    .o_hit        (w_hit),
    .o_data       (w_hit_data),
    .i_we         (w_fill && rdy_in),
    .i_waddr      (r_mem_addr[ADDR_W-1:2]),
    .i_wdata      (memData_in)
  );

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state <= StIdle;
    end else if (rdy_in) begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:    if ((pcJump_in != JUMP) && !w_stall && !w_hit) w_state_d = StWaitMem;
      StWaitMem: if (memDone_in) w_state_d = StIdle;
      default:   w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_pc_d       = r_pc;
    w_mem_req_d  = r_mem_req;
    w_mem_addr_d = r_mem_addr;
    w_inst_e_d   = 1'b0;
    w_pc_out_d   = r_pc_out;
    w_inst_out_d = r_inst_out;
    w_fill       = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (pcJump_in == JUMP) begin
          w_pc_d = word_align(pcTarget_in);
        end else if (w_stall) begin
          w_pc_d = r_pc;
        end else if (w_hit) begin
          w_inst_e_d   = 1'b1;
          w_pc_out_d   = r_pc;
          w_inst_out_d = w_hit_data;
          w_pc_d       = r_pc + 32'd4;
        end else begin
          w_mem_req_d  = 1'b1;
          w_mem_addr_d = r_pc;
        end
      end
      StWaitMem: begin
        // A redirect never aborts the fetch; the returning word is still valid for its address.
        if (pcJump_in == JUMP) w_pc_d = word_align(pcTarget_in);
        if (memDone_in) begin
          w_fill      = 1'b1;
          w_mem_req_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_pc       <= RESET_PC;
      r_mem_req  <= 1'b0;
      r_mem_addr <= ZERO32;
      r_inst_e   <= 1'b0;
      r_pc_out   <= ZERO32;
      r_inst_out <= '0;
    end else if (rdy_in) begin
      r_pc       <= w_pc_d;
      r_mem_req  <= w_mem_req_d;
      r_mem_addr <= w_mem_addr_d;
      r_inst_e   <= w_inst_e_d;
      r_pc_out   <= w_pc_out_d;
      r_inst_out <= w_inst_out_d;
    end
  end

  assign memReq_out  = r_mem_req;
  assign memAddr_out = r_mem_addr;
  assign instE_out   = r_inst_e;
  assign pc_out      = r_pc_out;
  assign inst_out    = r_inst_out;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: miss/fill/hit timing, loops, redirects, stalls,
// conflicts, rdy freeze and asynchronous reset during an outstanding fetch.
module tb_if_fetch_stage;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic [5:0]  stall_in;
  logic        pcJump_in;
  logic [31:0] pcTarget_in;
  logic        memDone_in;
  logic [31:0] memData_in;
  logic        memReq_out;
  logic [31:0] memAddr_out;
  logic        instE_out;
  logic [31:0] pc_out;
  logic [31:0] inst_out;

  int n_checks = 0;
  int n_fail   = 0;

  if_fetch_stage #(
    .ICACHE_IDX_W(5),
    .RESET_PC    (32'h0)
  ) dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .rdy_in     (rdy_in),
    .stall_in   (stall_in),
    .pcJump_in  (pcJump_in),
    .pcTarget_in(pcTarget_in),
    .memDone_in (memDone_in),
    .memData_in (memData_in),
    .memReq_out (memReq_out),
    .memAddr_out(memAddr_out),
    .instE_out  (instE_out),
    .pc_out     (pc_out),
    .inst_out   (inst_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Memory responder: memReq_out is already high; memDone_in is sampled lat edges after request.
  task automatic serve(input int lat, input logic [31:0] data);
    repeat (lat - 1) tick();
    memDone_in = 1'b1;
    memData_in = data;
    tick();
    memDone_in = 1'b0;
  endtask

  task automatic jump_to(input logic [31:0] target);
    pcJump_in   = 1'b1;
    pcTarget_in = target;
    tick();
    pcJump_in   = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_checks++; if (memReq_out !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %0b want 0", memReq_out); end
    n_checks++; if (memAddr_out !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %h want 0", memAddr_out); end
    n_checks++; if (instE_out !== 1'b0) begin n_fail++; $display("FAIL rst_inste: got %0b want 0", instE_out); end
    n_checks++; if (pc_out !== 32'h0) begin n_fail++; $display("FAIL rst_pc: got %h want 0", pc_out); end
    n_checks++; if (inst_out !== 32'h0) begin n_fail++; $display("FAIL rst_inst: got %h want 0", inst_out); end
    @(negedge clk_in);
    rst_in = 1'b1;
    tick();
    n_checks++; if (memReq_out !== 1'b1) begin n_fail++; $display("FAIL c1_req: got %0b want 1", memReq_out); end
    n_checks++; if (memAddr_out !== 32'h0) begin n_fail++; $display("FAIL c1_addr: got %h want 0", memAddr_out); end
    serve(3, 32'h0000_0013);
    n_checks++; if (memReq_out !== 1'b0 || instE_out !== 1'b0) begin n_fail++; $display("FAIL c4_done: req %0b inste %0b want 0 0", memReq_out, instE_out); end
    tick();
    n_checks++; if (instE_out !== 1'b1 || pc_out !== 32'h0 || inst_out !== 32'h13) begin n_fail++; $display("FAIL c5_deliver: inste %0b pc %h inst %h want 1 0 13", instE_out, pc_out, inst_out); end
    tick();
    n_checks++; if (memReq_out !== 1'b1 || memAddr_out !== 32'h4 || instE_out !== 1'b0) begin n_fail++; $display("FAIL c6_req4: req %0b addr %h inste %0b want 1 4 0", memReq_out, memAddr_out, instE_out); end
  endtask

  task automatic test_loop();
    logic [31:0] exp_inst;
    serve(2, 32'hC0DE_0004);
    tick();
    n_checks++; if (instE_out !== 1'b1 || pc_out !== 32'h4) begin n_fail++; $display("FAIL loop_d4: inste %0b pc %h want 1 4", instE_out, pc_out); end
    tick();
    n_checks++; if (memReq_out !== 1'b1 || memAddr_out !== 32'h8) begin n_fail++; $display("FAIL loop_req8: req %0b addr %h want 1 8", memReq_out, memAddr_out); end
    serve(2, 32'hC0DE_0008);
    tick();
    tick();
    n_checks++; if (memReq_out !== 1'b1 || memAddr_out !== 32'hC) begin n_fail++; $display("FAIL loop_reqC: req %0b addr %h want 1 c", memReq_out, memAddr_out); end
    serve(2, 32'hC0DE_000C);
    tick();
    n_checks++; if (inst_out !== 32'hC0DE_000C || pc_out !== 32'hC) begin n_fail++; $display("FAIL loop_dC: pc %h inst %h want c c0de000c", pc_out, inst_out); end
    jump_to(32'h0);
    n_checks++; if (instE_out !== 1'b0 || memReq_out !== 1'b0) begin n_fail++; $display("FAIL loop_jump: inste %0b req %0b want 0 0", instE_out, memReq_out); end
    for (int i = 0; i < 4; i++) begin
      tick();
      exp_inst = (i == 0) ? 32'h13 : (32'hC0DE_0000 | (i * 4));
      n_checks++;
      if (instE_out !== 1'b1 || pc_out !== i * 4 || inst_out !== exp_inst || memReq_out !== 1'b0) begin
        n_fail++;
        $display("FAIL loop_pass2_%0d: inste %0b pc %h inst %h req %0b want 1 %h %h 0", i, instE_out, pc_out, inst_out, memReq_out, i * 4, exp_inst);
      end
    end
  endtask

  task automatic test_jump_wait();
    jump_to(32'h88);
    tick();
    n_checks++; if (memReq_out !== 1'b1 || memAddr_out !== 32'h88) begin n_fail++; $display("FAIL jw_req88: req %0b addr %h want 1 88", memReq_out, memAddr_out); end
    serve(2, 32'hC0DE_0088);
    tick();
    n_checks++; if (instE_out !== 1'b1 || pc_out !== 32'h88) begin n_fail++; $display("FAIL jw_d88: inste %0b pc %h want 1 88", instE_out, pc_out); end
    jump_to(32'h8);
    tick();
    n_checks++; if (memReq_out !== 1'b1 || memAddr_out !== 32'h8) begin n_fail++; $display("FAIL jw_req8: req %0b addr %h want 1 8", memReq_out, memAddr_out); end
    tick();
    jump_to(32'h103);
    n_checks++; if (memReq_out !== 1'b1 || memAddr_out !== 32'h8 || instE_out !== 1'b0) begin n_fail++; $display("FAIL jw_hold: req %0b addr %h inste %0b want 1 8 0", memReq_out, memAddr_out, instE_out); end
    memDone_in = 1'b1;
    memData_in = 32'hC0DE_0008;
    tick();
    memDone_in = 1'b0;
    n_checks++; if (memReq_out !== 1'b0 || instE_out !== 1'b0) begin n_fail++; $display("FAIL jw_done: req %0b inste %0b want 0 0", memReq_out, instE_out); end
    tick();
    n_checks++; if (memReq_out !== 1'b1 || memAddr_out !== 32'h100 || instE_out !== 1'b0) begin n_fail++; $display("FAIL jw_req100: req %0b addr %h inste %0b want 1 100 0", memReq_out, memAddr_out, instE_out); end
    serve(2, 32'hC0DE_0100);
    tick();
    n_checks++; if (instE_out !== 1'b1 || pc_out !== 32'h100 || inst_out !== 32'hC0DE_0100) begin n_fail++; $display("FAIL jw_d100: inste %0b pc %h inst %h want 1 100 c0de0100", instE_out, pc_out, inst_out); end
    jump_to(32'h8);
    tick();
    n_checks++; if (instE_out !== 1'b1 || pc_out !== 32'h8 || inst_out !== 32'hC0DE_0008 || memReq_out !== 1'b0) begin n_fail++; $display("FAIL jw_filled8: inste %0b pc %h inst %h req %0b want 1 8 c0de0008 0", instE_out, pc_out, inst_out, memReq_out); end
  endtask

  task automatic test_stall();
    stall_in = 6'b000001;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (instE_out !== 1'b0 || memReq_out !== 1'b0) begin n_fail++; $display("FAIL stall_%0d: inste %0b req %0b want 0 0", i, instE_out, memReq_out); end
    end
    stall_in = 6'b000000;
    tick();
    n_checks++; if (instE_out !== 1'b1 || pc_out !== 32'hC) begin n_fail++; $display("FAIL stall_release: inste %0b pc %h want 1 c", instE_out, pc_out); end
    stall_in = 6'b000001;
    jump_to(32'h4);
    n_checks++; if (instE_out !== 1'b0 || memReq_out !== 1'b0) begin n_fail++; $display("FAIL stall_jump: inste %0b req %0b want 0 0", instE_out, memReq_out); end
    tick();
    stall_in = 6'b000000;
    tick();
    n_checks++; if (instE_out !== 1'b1 || pc_out !== 32'h4 || memReq_out !== 1'b0) begin n_fail++; $display("FAIL stall_target: inste %0b pc %h req %0b want 1 4 0", instE_out, pc_out, memReq_out); end
  endtask

  task automatic test_conflict();
    jump_to(32'h80);
    tick();
    n_checks++; if (memReq_out !== 1'b1 || memAddr_out !== 32'h80) begin n_fail++; $display("FAIL cf_req80: req %0b addr %h want 1 80", memReq_out, memAddr_out); end
    serve(2, 32'hC0DE_0080);
    tick();
    n_checks++; if (instE_out !== 1'b1 || pc_out !== 32'h80 || inst_out !== 32'hC0DE_0080) begin n_fail++; $display("FAIL cf_d80: inste %0b pc %h inst %h want 1 80 c0de0080", instE_out, pc_out, inst_out); end
    jump_to(32'h0);
    tick();
    n_checks++; if (memReq_out !== 1'b1 || memAddr_out !== 32'h0 || instE_out !== 1'b0) begin n_fail++; $display("FAIL cf_evict: req %0b addr %h inste %0b want 1 0 0", memReq_out, memAddr_out, instE_out); end
    serve(2, 32'h0000_0013);
    tick();
    n_checks++; if (instE_out !== 1'b1 || pc_out !== 32'h0 || inst_out !== 32'h13) begin n_fail++; $display("FAIL cf_d0: inste %0b pc %h inst %h want 1 0 13", instE_out, pc_out, inst_out); end
  endtask

  task automatic test_rdy_reset();
    tick();
    n_checks++; if (instE_out !== 1'b1 || pc_out !== 32'h4) begin n_fail++; $display("FAIL rdy_pre: inste %0b pc %h want 1 4", instE_out, pc_out); end
    rdy_in = 1'b0;
    tick();
    tick();
    n_checks++; if (instE_out !== 1'b1 || pc_out !== 32'h4 || inst_out !== 32'hC0DE_0004 || memReq_out !== 1'b0) begin n_fail++; $display("FAIL rdy_freeze: inste %0b pc %h inst %h req %0b want 1 4 c0de0004 0", instE_out, pc_out, inst_out, memReq_out); end
    rdy_in = 1'b1;
    tick();
    n_checks++; if (instE_out !== 1'b1 || pc_out !== 32'h8) begin n_fail++; $display("FAIL rdy_resume: inste %0b pc %h want 1 8", instE_out, pc_out); end
    tick();
    tick();
    n_checks++; if (memReq_out !== 1'b1 || memAddr_out !== 32'h10) begin n_fail++; $display("FAIL rdy_req10: req %0b addr %h want 1 10", memReq_out, memAddr_out); end
    rdy_in     = 1'b0;
    memDone_in = 1'b1;
    memData_in = 32'hBAD0_0010;
    tick();
    memDone_in = 1'b0;
    rdy_in     = 1'b1;
    n_checks++; if (memReq_out !== 1'b1 || memAddr_out !== 32'h10) begin n_fail++; $display("FAIL rdy_wait_hold: req %0b addr %h want 1 10", memReq_out, memAddr_out); end
    #2 rst_in = 1'b0;
    #1;
    n_checks++; if (memReq_out !== 1'b0 || memAddr_out !== 32'h0 || instE_out !== 1'b0) begin n_fail++; $display("FAIL async_rst: req %0b addr %h inste %0b want 0 0 0", memReq_out, memAddr_out, instE_out); end
    #2;
    rst_in     = 1'b1;
    memDone_in = 1'b1;
    memData_in = 32'hDEAD_BEEF;
    tick();
    memDone_in = 1'b0;
    n_checks++; if (memReq_out !== 1'b1 || memAddr_out !== 32'h0 || instE_out !== 1'b0) begin n_fail++; $display("FAIL late_done: req %0b addr %h inste %0b want 1 0 0", memReq_out, memAddr_out, instE_out); end
    tick();
    n_checks++; if (memReq_out !== 1'b1) begin n_fail++; $display("FAIL late_wait: req %0b want 1", memReq_out); end
    serve(2, 32'h0000_0013);
    tick();
    n_checks++; if (instE_out !== 1'b1 || pc_out !== 32'h0 || inst_out !== 32'h13) begin n_fail++; $display("FAIL late_refetch: inste %0b pc %h inst %h want 1 0 13", instE_out, pc_out, inst_out); end
  endtask

  initial begin
    rst_in      = 1'b0;
    rdy_in      = 1'b1;
    stall_in    = 6'b0;
    pcJump_in   = 1'b0;
    pcTarget_in = 32'h0;
    memDone_in  = 1'b0;
    memData_in  = 32'h0;
    test_reset();
    test_loop();
    test_jump_wait();
    test_stall();
    test_conflict();
    test_rdy_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
